// File: rtl/pq_ctrl.sv
// pq_ctrl: sequencing controller for a 6-entry sorted priority queue.
// It turns an insert stream (valid/ready) and a pop stream (request/grant)
// into loadIn/shiftOut/clear commands for the queue. It issues at most one
// queue operation per cycle and tracks occupancy. Popped values are
// registered with one cycle of latency.
// Optional feature macro: PQ_CTRL_STATS_EN adds the rej_cnt and max_cnt
// statistics outputs.
module pq_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 6
) (
  input  logic                         ck,
  input  logic                         r_n,
  input  logic                         ins_valid,
  input  logic [W-1:0]                 ins_data,
  output logic                         ins_ready,
  input  logic                         pop_req,
  output logic                         pop_gnt,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  input  logic                         flush_req,
  input  logic                         drain_req,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [W-1:0]                 q_newVal,
  output logic                         q_loadIn,
  output logic                         q_shiftOut,
  output logic                         q_clear,
  input  logic [W-1:0]                 q_top
`ifdef PQ_CTRL_STATS_EN
  ,
  output logic [15:0]                  rej_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   max_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_ins_q, last_ins_d;   // 1: last grant was an insert
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;

  logic          ins_elig, pop_elig;
  logic          grant_ins, grant_pop;
  logic          do_shift, do_clear;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign ins_elig = ins_valid & ~full;
  assign pop_elig = pop_req & ~empty;

  // Next-state, arbitration and occupancy decisions for the current cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    last_ins_d = last_ins_q;
    grant_ins  = 1'b0;
    grant_pop  = 1'b0;
    do_shift   = 1'b0;
    do_clear   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (drain_req && !empty) begin
          state_d = ST_DRAIN;
        end else begin
          // Round-robin only matters when both are eligible; a full queue
          // makes insert ineligible so pop wins, an empty one the reverse.
          grant_pop = pop_elig & (~ins_elig | last_ins_q);
          grant_ins = ins_elig & ~grant_pop;
          if (grant_ins) begin
            count_d    = count_q + CW'(1);
            last_ins_d = 1'b1;
          end
          if (grant_pop) begin
            count_d    = count_q - CW'(1);
            last_ins_d = 1'b0;
          end
          do_shift = grant_pop;
        end
      end
      ST_FLUSH: begin
        do_clear = 1'b1;
        count_d  = '0;
        state_d  = ST_RUN;
      end
      ST_DRAIN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (!empty) begin
          do_shift = 1'b1;
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, occupancy, arbitration history and popped-value capture.
  always_ff @(posedge ck or negedge r_n) begin
    if (!r_n) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      last_ins_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      count_q     <= count_d;
      last_ins_q  <= last_ins_d;
      out_valid_q <= do_shift;
      if (do_shift) out_data_q <= q_top;
    end
  end

  // Queue commands and handshakes are forced low while reset is asserted.
  assign ins_ready  = r_n & grant_ins;
  assign pop_gnt    = r_n & grant_pop;
  assign q_loadIn   = r_n & grant_ins;
  assign q_shiftOut = r_n & do_shift;
  assign q_clear    = r_n & do_clear;
  assign q_newVal   = r_n ? ins_data : '0;

  assign busy      = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef PQ_CTRL_STATS_EN
  logic [15:0]   rej_cnt_q;
  logic [CW-1:0] max_cnt_q;

  // Saturating rejected-insert counter and occupancy high-water mark.
  always_ff @(posedge ck or negedge r_n) begin
    if (!r_n) begin
      rej_cnt_q <= '0;
      max_cnt_q <= '0;
    end else if (do_clear) begin
      rej_cnt_q <= '0;
      max_cnt_q <= '0;
    end else begin
      if (ins_valid && !grant_ins && rej_cnt_q != 16'hFFFF)
        rej_cnt_q <= rej_cnt_q + 16'd1;
      if (count_d > max_cnt_q) max_cnt_q <= count_d;
    end
  end

  assign rej_cnt = rej_cnt_q;
  assign max_cnt = max_cnt_q;
`endif

endmodule

// File: tb/tb_pq_ctrl.sv
// tb_pq_ctrl: self-checking bench for pq_ctrl. A behavioural sorted-list
// reference predicts every control output each cycle and pushes expected
// popped values into a scoreboard; a monitor pops it whenever out_valid is
// seen. A second list plays the part of the real queue and drives q_top from
// the DUT's own commands.
module tb_pq_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH+1);

  localparam int M_RUN   = 0;
  localparam int M_FLUSH = 1;
  localparam int M_DRAIN = 2;

  typedef int iq_t[$];

  logic          ck = 1'b0;
  logic          r_n = 1'b0;
  logic          ins_valid = 1'b0;
  logic [W-1:0]  ins_data = '0;
  logic          ins_ready;
  logic          pop_req = 1'b0;
  logic          pop_gnt;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          flush_req = 1'b0;
  logic          drain_req = 1'b0;
  logic          busy;
  logic [CW-1:0] count;
  logic          full, empty;
  logic [W-1:0]  q_newVal;
  logic          q_loadIn, q_shiftOut, q_clear;
  logic [W-1:0]  q_top = '0;
`ifdef PQ_CTRL_STATS_EN
  logic [15:0]   rej_cnt;
  logic [CW-1:0] max_cnt;
`endif

  pq_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .ck(ck), .r_n(r_n),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready),
    .pop_req(pop_req), .pop_gnt(pop_gnt),
    .out_valid(out_valid), .out_data(out_data),
    .flush_req(flush_req), .drain_req(drain_req), .busy(busy),
    .count(count), .full(full), .empty(empty),
    .q_newVal(q_newVal), .q_loadIn(q_loadIn), .q_shiftOut(q_shiftOut),
    .q_clear(q_clear), .q_top(q_top)
`ifdef PQ_CTRL_STATS_EN
    , .rej_cnt(rej_cnt), .max_cnt(max_cnt)
`endif
  );

  always #10 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic iq_t ins_sorted(iq_t q, int v);
    int i = 0;
    while (i < q.size() && q[i] >= v) i++;
    q.insert(i, v);
    return q;
  endfunction

  // Reference model state.
  iq_t m_l;
  int  m_mode = M_RUN;
  bit  m_last_ins = 1'b0;
  int  m_rej = 0, m_max = 0;
  int  exp_q[$];
  int  got_q[$];
  bit  p_ok = 0, p_ins, p_sh, p_clr, p_last;
  int  p_mode, p_val, p_rej, p_max;

  // Stand-in queue driven by the DUT's commands.
  iq_t env_l;
  bit  s_ok = 0, s_ld, s_sh, s_clr;
  int  s_val;

  always @(negedge r_n) begin
    m_l.delete(); m_mode = M_RUN; m_last_ins = 1'b0; m_rej = 0; m_max = 0;
    exp_q.delete(); p_ok = 0;
    env_l.delete(); s_ok = 0; q_top = '0;
  end

  // Monitor, reference prediction and queue-command snapshot, mid-cycle.
  always @(negedge ck) begin
    int n, nn;
    bit ci, cp, t_ins, t_pop, t_sh, t_clr;
    if (!r_n) begin
      check("rst_ctl", {ins_ready, pop_gnt, q_loadIn, q_shiftOut, q_clear}, 0);
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid) got_q.push_back(int'(out_data));
      if (exp_q.size() != 0) begin
        if (out_valid) check("out_data", out_data, exp_q[0]);
        exp_q.delete();
      end

      n = m_l.size();
      t_ins = 0; t_pop = 0; t_sh = 0; t_clr = 0;
      p_mode = m_mode; p_last = m_last_ins;
      if (m_mode == M_RUN) begin
        if (flush_req) p_mode = M_FLUSH;
        else if (drain_req && n > 0) p_mode = M_DRAIN;
        else begin
          ci = ins_valid && n < DEPTH;
          cp = pop_req && n > 0;
          t_pop = cp && (!ci || m_last_ins);
          t_ins = ci && !t_pop;
          if (t_ins) p_last = 1'b1;
          if (t_pop) p_last = 1'b0;
        end
      end else if (m_mode == M_FLUSH) begin
        t_clr = 1; p_mode = M_RUN;
      end else begin
        if (flush_req) p_mode = M_FLUSH;
        else begin
          t_sh = 1;
          if (n == 1) p_mode = M_RUN;
        end
      end
      t_sh = t_sh | t_pop;

      check("ctl", {ins_ready, pop_gnt, q_loadIn, q_shiftOut, q_clear, busy, full, empty},
            {t_ins, t_pop, t_ins, t_sh, t_clr, m_mode != M_RUN, n == DEPTH, n == 0});
      check("count", count, n);
      check("q_newVal", q_newVal, ins_data);
`ifdef PQ_CTRL_STATS_EN
      check("rej_cnt", rej_cnt, m_rej);
      check("max_cnt", max_cnt, m_max);
`endif
      if (t_sh) exp_q.push_back(m_l[0]);

      nn = t_clr ? 0 : n + int'(t_ins) - int'(t_sh);
      if (t_clr) begin
        p_rej = 0; p_max = 0;
      end else begin
        p_rej = (ins_valid && !t_ins && m_rej < 65535) ? m_rej + 1 : m_rej;
        p_max = (nn > m_max) ? nn : m_max;
      end
      p_ins = t_ins; p_sh = t_sh; p_clr = t_clr; p_val = int'(ins_data);
      p_ok = 1;
    end
    s_ld = q_loadIn; s_sh = q_shiftOut; s_clr = q_clear; s_val = int'(q_newVal);
    s_ok = r_n;
  end

  // Advance the reference at the edge; update the stand-in queue just after.
  always @(posedge ck) begin
    if (r_n && p_ok) begin
      if (p_clr) m_l.delete();
      if (p_sh && m_l.size() > 0) void'(m_l.pop_front());
      if (p_ins) m_l = ins_sorted(m_l, p_val);
      m_mode = p_mode; m_last_ins = p_last; m_rej = p_rej; m_max = p_max;
    end
    p_ok = 0;
    #1;
    if (s_ok) begin
      if (s_clr) env_l.delete();
      if (s_sh && env_l.size() > 0) void'(env_l.pop_front());
      if (s_ld) env_l = ins_sorted(env_l, s_val);
      q_top = (env_l.size() > 0) ? W'(env_l[0]) : '0;
    end
    s_ok = 0;
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic insert(input int v);
    ins_valid = 1'b1; ins_data = W'(v);
    step();
    ins_valid = 1'b0;
  endtask

  task automatic check_seq(input string name, input iq_t e);
    check({name, "_len"}, got_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < got_q.size()) check(name, got_q[i], e[i]);
  endtask

  initial begin
    int idx;
    iq_t dl;

    // Reset: handshakes stay low even with an insert pending.
    ins_valid = 1'b1; ins_data = 8'd77;
    #12;
    check("rst_ins_ready", ins_ready, 0);
    check("rst_q_loadIn", q_loadIn, 0);
    ins_valid = 1'b0;
    #13 r_n = 1'b1;
    #2;
    check("rst_state", {out_valid, busy, empty, full}, 4'b0010);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    step();

    // Fill to capacity, reject the seventh insert, then pop everything.
    foreach (dl[i]) dl.delete();
    insert(12); insert(40); insert(7); insert(99); insert(3); insert(55);
    ins_valid = 1'b1; ins_data = 8'd80;
    #2;
    check("t1_count", count, 6);
    check("t1_full", full, 1);
    check("t1_ready_full", ins_ready, 0);
    step();
    ins_valid = 1'b0; pop_req = 1'b1; got_q.delete();
    for (int i = 0; i < 6; i++) begin
      #2 check("t1_pop_gnt", pop_gnt, 1);
      step();
    end
    pop_req = 1'b0;
    step();
    check_seq("t1_pops", '{99, 55, 40, 12, 7, 3});
    check("t1_empty", empty, 1);

    // Round-robin with both streams held high, one preloaded entry.
    insert(50);
    got_q.delete();
    dl = '{10, 20, 30};
    idx = 0;
    ins_valid = 1'b1; pop_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ins_data = W'(dl[(idx < 3) ? idx : 2]);
      #2;
      check("t2_pop_gnt", pop_gnt, (c % 2) == 0);
      check("t2_ins_ready", ins_ready, (c % 2) == 1);
      if (ins_ready) idx++;
      step();
    end
    ins_valid = 1'b0; pop_req = 1'b0;
    check_seq("t2_pops", '{50, 10, 20});
    pop_req = 1'b1; step(); pop_req = 1'b0; step();

    // Drain three entries back-to-back.
    insert(9); insert(8); insert(7);
    got_q.delete();
    drain_req = 1'b1; step(); drain_req = 1'b0;
    ins_valid = 1'b1; ins_data = 8'd1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("t3_busy", busy, 1);
      check("t3_ins_ready", ins_ready, 0);
      step();
    end
    ins_valid = 1'b0;
    #2;
    check("t3_busy_end", busy, 0);
    check("t3_count_end", count, 0);
    step();
    check_seq("t3_pops", '{9, 8, 7});

    // Flush competing with both requests, then an immediate insert.
    insert(1); insert(2); insert(3); insert(4);
    flush_req = 1'b1; ins_valid = 1'b1; pop_req = 1'b1; ins_data = 8'd6;
    #2 check("t4_req_grants", {ins_ready, pop_gnt, q_clear}, 0);
    step();
    flush_req = 1'b0;
    #2 check("t4_flush", {ins_ready, pop_gnt, q_clear}, 3'b001);
    step();
    ins_data = 8'd5;
    #2;
    check("t4_count_after", count, 0);
    check("t4_ins5", {ins_ready, pop_gnt}, 2'b10);
    step();
    ins_valid = 1'b0; pop_req = 1'b0;

    // Reset pulse in the middle of a four-entry drain.
    insert(2); insert(6); insert(4);
    drain_req = 1'b1; step(); drain_req = 1'b0;
    step();
    @(negedge ck);
    #1 r_n = 1'b0;
    #3 r_n = 1'b1;
    #2;
    check("t5_count", count, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_shift", q_shiftOut, 0);
    step();

`ifdef PQ_CTRL_STATS_EN
    flush_req = 1'b1; step(); flush_req = 1'b0; step();
    check("t6_rej_clr0", rej_cnt, 0);
    for (int i = 0; i < 6; i++) insert(10 * i + 1);
    ins_valid = 1'b1;
    repeat (10) step();
    ins_valid = 1'b0;
    #2;
    check("t6_rej", rej_cnt, 10);
    check("t6_max", max_cnt, 6);
    step();
    flush_req = 1'b1; step(); flush_req = 1'b0; step();
    check("t6_rej_clr", rej_cnt, 0);
    check("t6_max_clr", max_cnt, 0);
`endif

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      ins_valid = ($urandom_range(0, 9) < 6);
      ins_data  = W'($urandom);
      pop_req   = ($urandom_range(0, 1) == 1);
      drain_req = ($urandom_range(0, 99) < 3);
      flush_req = ($urandom_range(0, 99) < 2);
      step();
    end
    ins_valid = 1'b0; pop_req = 1'b0; drain_req = 1'b0; flush_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
